// File: rtl/axis_frame_tx_buffer.sv
// Transmit frame source: a byte-masked word buffer is streamed out as one AXI4-Stream frame per send
// command, padded to a minimum length, with an abort path that ends the frame marked bad (tuser=1).
module axis_frame_tx_buffer #(
  parameter int DATA_WIDTH      = 32,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int BUF_WORDS       = 512,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int LEN_WIDTH       = $clog2(BUF_WORDS * KEEP_WIDTH) + 1
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         wr_v_i,
  output logic                         wr_ready_o,
  input  logic [$clog2(BUF_WORDS)-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]        wr_data_i,
  input  logic [KEEP_WIDTH-1:0]        wr_mask_i,
  input  logic                         send_v_i,
  output logic                         send_ready_o,
  input  logic [LEN_WIDTH-1:0]         send_len_i,
  input  logic                         abort_i,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tuser,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o
);

  localparam int AW        = $clog2(BUF_WORDS);
  localparam int CW        = LEN_WIDTH + 1;
  localparam int BUF_BYTES = BUF_WORDS * KEEP_WIDTH;

  typedef enum logic [1:0] {IDLE, PREFETCH, SEND, DONE} state_t;
  state_t state;

  logic [DATA_WIDTH-1:0] mem [BUF_WORDS];
  logic [DATA_WIDTH-1:0] rd_data_p0;
  logic [AW-1:0]         rd_addr;
  logic                  rd_en;

  logic [DATA_WIDTH-1:0] tdata_p1;
  logic [KEEP_WIDTH-1:0] tkeep_p1;
  logic                  tlast_p1, tuser_p1, vld_p1;
  logic                  busy, done, error;

  logic [CW-1:0]         len_q, n_beats_q, load_cnt;
  logic [KEEP_WIDTH-1:0] last_keep_q;
  logic                  last_loaded;

  logic [CW-1:0]         len_ext, eff_len, cmd_beats, rem, base;
  logic [KEEP_WIDTH-1:0] cmd_keep, beat_keep;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  cmd_ok, beat_last, load;

  assign wr_ready_o    = ~busy;
  assign send_ready_o  = ~busy;
  assign busy_o        = busy;
  assign done_o        = done;
  assign error_o       = error;
  assign m_axis_tdata  = tdata_p1;
  assign m_axis_tkeep  = tkeep_p1;
  assign m_axis_tlast  = tlast_p1;
  assign m_axis_tuser  = tuser_p1;
  assign m_axis_tvalid = vld_p1;

  // Command decode: padded length, beat count and keep mask of the final beat.
  always_comb begin
    len_ext   = CW'(send_len_i);
    cmd_ok    = (send_len_i != '0) && (len_ext <= CW'(BUF_BYTES));
    eff_len   = (len_ext < CW'(MIN_FRAME_BYTES)) ? CW'(MIN_FRAME_BYTES) : len_ext;
    cmd_beats = (eff_len + CW'(KEEP_WIDTH - 1)) / CW'(KEEP_WIDTH);
    rem       = eff_len % CW'(KEEP_WIDTH);
    for (int b = 0; b < KEEP_WIDTH; b++)
      cmd_keep[b] = (rem == '0) || (CW'(b) < rem);
  end

  // Beat assembly from the prefetched word; bytes at or past the command length become pad.
  always_comb begin
    load      = (state == SEND) && !last_loaded && (!vld_p1 || m_axis_tready);
    base      = CW'(load_cnt * CW'(KEEP_WIDTH));
    beat_last = (load_cnt == n_beats_q - CW'(1));
    beat_keep = beat_last ? last_keep_q : '1;
    for (int b = 0; b < KEEP_WIDTH; b++)
      beat_data[8*b +: 8] = (base + CW'(b) < len_q) ? rd_data_p0[8*b +: 8] : 8'h00;
    rd_en   = 1'b0;
    rd_addr = '0;
    if (state == PREFETCH) begin
      rd_en = 1'b1;
    end else if (load) begin
      rd_en   = 1'b1;
      rd_addr = AW'(load_cnt + CW'(1));
    end
  end

  // Stage p0: byte-masked buffer write and registered read of the next word.
  always_ff @(posedge clk_i) begin
    if (wr_v_i && !busy)
      for (int b = 0; b < KEEP_WIDTH; b++)
        if (wr_mask_i[b]) mem[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
    if (rd_en) rd_data_p0 <= mem[rd_addr];
  end

  // Stage p1: frame control and the registered AXIS output beat.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      vld_p1      <= 1'b0;
      tdata_p1    <= '0;
      tkeep_p1    <= '0;
      tlast_p1    <= 1'b0;
      tuser_p1    <= 1'b0;
      last_loaded <= 1'b0;
      load_cnt    <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: if (send_v_i) begin
          if (cmd_ok) begin
            state       <= PREFETCH;
            busy        <= 1'b1;
            len_q       <= len_ext;
            n_beats_q   <= cmd_beats;
            last_keep_q <= cmd_keep;
          end else begin
            error <= 1'b1;
          end
        end
        PREFETCH: begin
          state       <= SEND;
          load_cnt    <= '0;
          last_loaded <= 1'b0;
        end
        SEND: begin
          if (vld_p1 && m_axis_tready && tlast_p1) begin
            vld_p1   <= 1'b0;
            tdata_p1 <= '0;
            tkeep_p1 <= '0;
            tlast_p1 <= 1'b0;
            tuser_p1 <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else if (load) begin
            vld_p1   <= 1'b1;
            load_cnt <= load_cnt + CW'(1);
            if (abort_i) begin
              tdata_p1    <= '0;
              tkeep_p1    <= '1;
              tlast_p1    <= 1'b1;
              tuser_p1    <= 1'b1;
              last_loaded <= 1'b1;
            end else begin
              tdata_p1    <= beat_data;
              tkeep_p1    <= beat_keep;
              tlast_p1    <= beat_last;
              tuser_p1    <= 1'b0;
              last_loaded <= beat_last;
            end
          end else if (abort_i && vld_p1) begin
            // Stalled beat: a real last beat only gains the bad marker, others become the abort beat.
            tuser_p1 <= 1'b1;
            if (!tlast_p1) begin
              tdata_p1    <= '0;
              tkeep_p1    <= '1;
              tlast_p1    <= 1'b1;
              last_loaded <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_tx_buffer.sv
// Randomized bench for axis_frame_tx_buffer: a byte-level buffer model predicts every frame,
// including padding, error commands, abort and mid-frame reset.
module tb_axis_frame_tx_buffer;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int BW = 512;
  localparam int MINB = 60;
  localparam int LW = 12;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset_n, wr_v, wr_ready, send_v, send_ready, abort;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data, tdata;
  logic [KW-1:0] wr_mask, tkeep;
  logic [LW-1:0] send_len;
  logic          tvalid, tready, tlast, tuser, busy, done, error;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] mem_model [BW];
  logic [37:0] exp_q[$];
  logic [37:0] cap_q[$];

  always #5 clk = ~clk;

  axis_frame_tx_buffer dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .wr_v_i(wr_v), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_mask_i(wr_mask),
    .send_v_i(send_v), .send_ready_o(send_ready), .send_len_i(send_len), .abort_i(abort),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .m_axis_tuser(tuser),
    .busy_o(busy), .done_o(done), .error_o(error)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic void model_write(input int addr, input logic [31:0] data, input logic [3:0] mask);
    for (int j = 0; j < KW; j++)
      if (mask[j]) mem_model[addr][8*j +: 8] = data[8*j +: 8];
  endfunction

  // Expected beats packed as {tlast, tuser, tkeep, tdata}.
  function automatic void build_exp(input int len);
    int l, n, byte_idx;
    logic [31:0] w, d;
    logic [3:0] k;
    exp_q.delete();
    l = (len < MINB) ? MINB : len;
    n = (l + KW - 1) / KW;
    for (int i = 0; i < n; i++) begin
      w = mem_model[i];
      d = '0;
      for (int j = 0; j < KW; j++) begin
        byte_idx = i * KW + j;
        if (byte_idx < len) d[8*j +: 8] = w[8*j +: 8];
      end
      k = 4'hF;
      if (i == n - 1 && (l % KW) != 0) k = 4'((1 << (l % KW)) - 1);
      exp_q.push_back({(i == n - 1), 1'b0, k, d});
    end
  endfunction

  task automatic wr_word(input int addr, input logic [31:0] data, input logic [3:0] mask);
    @(negedge clk);
    wr_v = 1'b1; wr_addr = AW'(addr); wr_data = data; wr_mask = mask;
    @(negedge clk);
    wr_v = 1'b0;
    model_write(addr, data, mask);
  endtask

  task automatic err_cmd(input int len);
    bit any_v;
    @(negedge clk);
    send_v = 1'b1; send_len = LW'(len);
    @(negedge clk);
    send_v = 1'b0;
    chk("err_pulse", error, 1);
    chk("err_busy", busy, 0);
    any_v = tvalid;
    repeat (4) begin
      @(negedge clk);
      any_v |= tvalid | busy;
    end
    chk("err_no_beats", any_v, 0);
    chk("err_pulse_clear", error, 0);
  endtask

  task automatic run_frame(input int len, input int rdy_pct, input int abort_after,
                           input int reset_after, input bit co_write);
    bit fin, aborted, prev_stall, prev_abort;
    int first_v, dones;
    logic [37:0] beat, prev_beat;
    fin = 0; aborted = 0; prev_stall = 0; prev_abort = 0;
    first_v = -1; dones = 0; prev_beat = '0;
    @(negedge clk);
    send_v = 1'b1; send_len = LW'(len);
    if (co_write) begin
      wr_v = 1'b1; wr_addr = '0; wr_data = 32'hA5C3_0F1E; wr_mask = 4'hF;
      model_write(0, 32'hA5C3_0F1E, 4'hF);
    end
    build_exp(len);
    @(negedge clk);
    send_v = 1'b0; wr_v = 1'b0;
    chk("busy_after_cmd", busy, 1);
    cap_q.delete();
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      beat = {tlast, tuser, tkeep, tdata};
      if (tvalid && first_v < 0) first_v = cyc;
      if (done) dones++;
      if (prev_stall && !prev_abort) chk("stall_hold", beat, prev_beat);
      if (reset_after >= 0 && cap_q.size() == reset_after) begin
        reset_n = 1'b0; tready = 1'b1;
        @(negedge clk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_send_ready", send_ready, 1);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1; tready = 1'b0;
        return;
      end
      abort = 1'b0;
      tready = ($urandom_range(99) < rdy_pct);
      if (abort_after >= 0 && !aborted && cap_q.size() == abort_after) begin
        abort = 1'b1; tready = 1'b0; aborted = 1;
      end
      prev_stall = tvalid && !tready;
      prev_abort = abort;
      prev_beat = beat;
      if (tvalid && tready) begin
        cap_q.push_back(beat);
        if (tlast) fin = 1;
      end
    end
    abort = 1'b0;
    chk("frame_end", fin, 1);
    chk("first_valid_latency", first_v, 2);
    chk("done_early", dones, 0);
    @(negedge clk);
    tready = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 1);
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("busy_clear", busy, 0);
    if (abort_after >= 0) begin
      while (exp_q.size() > abort_after) void'(exp_q.pop_back());
      exp_q.push_back({1'b1, 1'b1, 4'hF, 32'h0});
    end
    chk("beat_count", cap_q.size(), exp_q.size());
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      chk($sformatf("beat%0d_len%0d", i, len), cap_q[i], exp_q[i]);
  endtask

  initial begin
    reset_n = 1'b0; wr_v = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    send_v = 1'b0; send_len = '0; abort = 1'b0; tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {tvalid, tlast, tuser, tkeep, tdata, busy, done, error}, '0);
    chk("reset_ready", {wr_ready, send_ready}, 2'b11);
    reset_n = 1'b1;

    for (int a = 0; a < 32; a++) wr_word(a, $urandom, 4'hF);
    for (int a = 0; a < 16; a++) wr_word(a, 32'h0302_0100 + 32'h0404_0404 * a, 4'hF);

    run_frame(64, 100, -1, -1, 0);
    run_frame(70, 100, -1, -1, 0);
    run_frame(13, 100, -1, -1, 0);
    err_cmd(0);
    err_cmd(2049);
    run_frame(64, 50, -1, -1, 0);
    run_frame(64, 100, 5, -1, 0);
    run_frame(64, 100, -1, -1, 0);
    run_frame(64, 100, -1, 7, 0);
    run_frame(64, 100, -1, -1, 0);
    run_frame(8, 70, -1, -1, 1);

    for (int t = 0; t < 6; t++) begin
      for (int w = 0; w < 4; w++)
        wr_word($urandom_range(0, 24), $urandom, 4'($urandom_range(0, 15)));
      run_frame($urandom_range(1, 100), $urandom_range(30, 100), -1, -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
